axi_write_pairing_buffer: RTL and testbench

Upstream write-channel stage for the flattened AXI-like slave port of the SystemVerilog IP. It accepts independent AW and W handshakes from a bus master and pairs each address with its data. Paired beats are buffered in a small FIFO and presented downstream as one combined address+data+strobe beat with a single valid/ready handshake. It also generates the B-channel responses back to the master, one per downstream-accepted beat.

---
 rtl/axi_buf_pkg.sv | 5 +
 rtl/axi_write_pairing_buffer_sync_fifo.sv | 45 ++++
 rtl/axi_write_pairing_buffer.sv | 99 +++++++++
 tb/tb_axi_write_pairing_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_buf_pkg.sv
// axi_buf_pkg: shared constants for the AXI write pairing buffer.
//   RESP_OKAY - B-channel response code returned for every accepted write.
package axi_buf_pkg;
    localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/axi_write_pairing_buffer_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage and combinational head read.
//   clk, rst          - clock, synchronous active-high reset
//   push_i, din_i     - write enable and data (caller guarantees not full)
//   pop_i             - read enable (caller guarantees not empty)
//   head_o            - head entry, zero while empty
//   count_o           - occupied entries, 0..DEPTH
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    always_comb begin
        wr_d  = push_i ? wr_q + 1'b1 : wr_q;
        rd_d  = pop_i ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end
    // Gate the head so stale storage never shows after reset or once drained.
    assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
    assign count_o = cnt_q;
endmodule

// File: rtl/axi_write_pairing_buffer.sv
// axi_write_pairing_buffer: pairs AXI AW/W beats, buffers them and returns B responses.
//   clk_domain_a, rst            - clock, synchronous active-high reset
//   s_aw*/s_w*                   - master address and data channels (independent handshakes)
//   s_b*                         - write response channel, one OKAY per accepted beat
//   m_awvalid/m_aw*/m_w*/m_awready - combined address+data+strobe beat to the IP
//   fifo_count                   - pair-FIFO occupancy
module axi_write_pairing_buffer
    import axi_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                      clk_domain_a,
    input  logic                      rst,
    input  logic                      s_awvalid,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    output logic                      s_awready,
    input  logic                      s_wvalid,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    output logic                      s_wready,
    output logic                      s_bvalid,
    output logic [1:0]                s_bresp,
    input  logic                      s_bready,
    output logic                      m_awvalid,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    input  logic                      m_awready,
    output logic [$clog2(DEPTH):0]    fifo_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(2 * DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PMAX = PW'(2 * DEPTH);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   data;
        logic [DATA_WIDTH/8-1:0] strb;
    } pair_t;
    logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
    logic [PW-1:0]           pend_q, pend_d;
    logic                    push, pop, aw_hs, w_hs, b_hs;
    pair_t                   tail, head;
    always_comb begin
        // Full is judged on the registered count: a same-cycle pop never frees room.
        push      = aw_held_q & w_held_q & (fifo_count != FULL);
        s_awready = !aw_held_q | push;
        s_wready  = !w_held_q | push;
        aw_hs     = s_awvalid & s_awready;
        w_hs      = s_wvalid & s_wready;
        aw_held_d = aw_hs | (aw_held_q & !push);
        w_held_d  = w_hs | (w_held_q & !push);
        aw_addr_d = aw_hs ? s_awaddr : aw_addr_q;
        w_data_d  = w_hs ? s_wdata : w_data_q;
        w_strb_d  = w_hs ? s_wstrb : w_strb_q;
        // Stop issuing beats once the owed-response counter is saturated.
        m_awvalid = (fifo_count != '0) & (pend_q != PMAX);
        pop       = m_awvalid & m_awready;
        s_bvalid  = pend_q != '0;
        s_bresp   = RESP_OKAY;
        b_hs      = s_bvalid & s_bready;
        pend_d    = pend_q + PW'(pop) - PW'(b_hs);
        tail      = '{addr: aw_addr_q, data: w_data_q, strb: w_strb_q};
        m_awaddr  = head.addr;
        m_wdata   = head.data;
        m_wstrb   = head.strb;
    end
    always_ff @(posedge clk_domain_a) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            pend_q    <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            pend_q    <= pend_d;
        end
    end
    sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(pair_t))) u_fifo (
        .clk     (clk_domain_a),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (tail),
        .head_o  (head),
        .count_o (fifo_count)
    );
endmodule

// File: tb/tb_axi_write_pairing_buffer.sv
// tb_axi_write_pairing_buffer: directed stimulus with a scoreboard-driven monitor.
module tb_axi_write_pairing_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [15:0] s_awaddr, m_awaddr;
    logic [31:0] s_wdata, m_wdata;
    logic [3:0]  s_wstrb, m_wstrb;
    logic [1:0]  s_bresp;
    logic        m_awvalid, m_awready;
    logic [2:0]  fifo_count;

    typedef struct {logic [15:0] a; logic [31:0] d; logic [3:0] s;} beat_t;
    typedef struct {int sig; int exp;} probe_t;
    beat_t  exp_q[$];
    probe_t pq[$];
    int vectors = 0, miscompares = 0, owed = 0, cyc_no = 0, got;
    probe_t p;
    beat_t  e;

    axi_write_pairing_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(4)) dut (
        .clk_domain_a (clk),
        .rst          (rst),
        .s_awvalid    (s_awvalid),
        .s_awaddr     (s_awaddr),
        .s_awready    (s_awready),
        .s_wvalid     (s_wvalid),
        .s_wdata      (s_wdata),
        .s_wstrb      (s_wstrb),
        .s_wready     (s_wready),
        .s_bvalid     (s_bvalid),
        .s_bresp      (s_bresp),
        .s_bready     (s_bready),
        .m_awvalid    (m_awvalid),
        .m_awaddr     (m_awaddr),
        .m_wdata      (m_wdata),
        .m_wstrb      (m_wstrb),
        .m_awready    (m_awready),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    function automatic string nm(input int s);
        case (s)
            0: return "s_awready";
            1: return "s_wready";
            2: return "s_bvalid";
            3: return "m_awvalid";
            4: return "fifo_count";
            5: return "s_bresp";
            default: return "scoreboard_left";
        endcase
    endfunction

    function automatic int sample(input int s);
        case (s)
            0: return int'(s_awready);
            1: return int'(s_wready);
            2: return int'(s_bvalid);
            3: return int'(m_awvalid);
            4: return int'(fifo_count);
            5: return int'(s_bresp);
            default: return exp_q.size();
        endcase
    endfunction

    // Monitor: evaluates queued probes, then scores beats and responses as they are accepted.
    always @(negedge clk) begin
        while (pq.size() > 0) begin
            p = pq.pop_front();
            vectors++;
            got = sample(p.sig);
            if (got != p.exp) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %0d expected %0d", nm(p.sig), cyc_no, got, p.exp);
            end
        end
        if (rst) begin
            exp_q.delete();
            owed = 0;
        end else begin
            if (s_bvalid && s_bready) begin
                vectors++;
                if (owed == 0 || s_bresp !== 2'b00) begin
                    miscompares++;
                    $display("FAIL bresp cycle %0d: got resp %0d owed %0d expected resp 0 owed>0", cyc_no, s_bresp, owed);
                end
                if (owed > 0) owed--;
            end
            if (m_awvalid && m_awready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat cycle %0d: got addr %h with no beat expected", cyc_no, m_awaddr);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_awaddr, m_wdata, m_wstrb} !== {e.a, e.d, e.s}) begin
                        miscompares++;
                        $display("FAIL beat cycle %0d: got %h/%h/%h expected %h/%h/%h",
                                 cyc_no, m_awaddr, m_wdata, m_wstrb, e.a, e.d, e.s);
                    end
                end
                owed++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int s, input int x);
        pq.push_back('{s, x});
    endtask

    task automatic aw(input logic v, input logic [15:0] a);
        s_awvalid = v;
        s_awaddr  = a;
    endtask

    task automatic w(input logic v, input logic [31:0] d, input logic [3:0] s);
        s_wvalid = v;
        s_wdata  = d;
        s_wstrb  = s;
    endtask

    task automatic expect_beat(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_q.push_back('{a, d, s});
    endtask

    task automatic pair(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        aw(1'b1, a);
        w(1'b1, d, s);
        expect_beat(a, d, s);
    endtask

    task automatic idle();
        aw(1'b0, '0);
        w(1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s_bready = 1'b0;
        m_awready = 1'b0;
        idle();
        cyc();
        cyc();
        probe(0, 1); probe(1, 1); probe(2, 0); probe(3, 0); probe(4, 0); probe(5, 0);
        cyc();
        rst = 1'b0;
        m_awready = 1'b1;
        s_bready = 1'b1;
        cyc();
        // Simultaneous AW/W: beat visible two cycles later, B one cycle after pop.
        pair(16'h0010, 32'hDEADBEEF, 4'hF);
        probe(0, 1);
        cyc();
        idle();
        probe(3, 0);
        cyc();
        probe(3, 1);
        cyc();
        probe(2, 1); probe(5, 0);
        cyc();
        probe(2, 0);
        cyc();
        cyc();
        // AW leads W by five cycles.
        aw(1'b1, 16'h0020);
        probe(0, 1);
        cyc();
        aw(1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            probe(0, 0); probe(3, 0);
            cyc();
        end
        w(1'b1, 32'hCAFEF00D, 4'h3);
        expect_beat(16'h0020, 32'hCAFEF00D, 4'h3);
        probe(1, 1); probe(3, 0);
        cyc();
        idle();
        probe(3, 0);
        cyc();
        probe(3, 1);
        cyc();
        cyc();
        cyc();
        // Fill the FIFO with the sink stalled; fifth pair parks in the hold registers.
        m_awready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pair(16'h0100 + 16'(i), 32'h1000_0000 + 32'(i), 4'(i));
            cyc();
        end
        idle();
        probe(0, 0); probe(1, 0); probe(4, 4); probe(3, 1);
        cyc();
        m_awready = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        probe(4, 0); probe(6, 0); probe(2, 0);
        cyc();
        // Saturate owed responses: eight pops then issue stalls with data still buffered.
        s_bready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pair(16'h0200 + 16'(i), 32'hA000_0000 + 32'(i), 4'hF);
            cyc();
        end
        idle();
        cyc();
        cyc();
        probe(3, 0); probe(4, 2); probe(2, 1);
        s_bready = 1'b1;
        cyc();
        s_bready = 1'b0;
        probe(3, 1);
        cyc();
        probe(3, 0); probe(4, 1);
        cyc();
        // Clean restart, then build 3 buffered entries with 2 responses owed and reset mid-flight.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        probe(2, 0); probe(4, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) m_awready = 1'b0;
            pair(16'h0300 + 16'(i), 32'h5500_0000 + 32'(i), 4'hA);
            cyc();
        end
        idle();
        cyc();
        probe(4, 3); probe(2, 1); probe(3, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        probe(4, 0); probe(2, 0); probe(0, 1); probe(1, 1); probe(3, 0);
        cyc();
        cyc();
        probe(6, 0);
        cyc();
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
